// File: rtl/xc_malu_core.sv
// rtl/xc_malu_core.sv - multi-cycle multiply/divide unit with packed-lane multiply and single-cycle add/sub/accumulate ops.
// Divide and multiply iterate one bit per cycle; operands are read live since the requester holds them until ready.
module xc_malu_core (
    input  logic        clock,
    input  logic        reset,
    input  logic [31:0] rs1,
    input  logic [31:0] rs2,
    input  logic [31:0] rs3,
    input  logic        flush,
    input  logic        valid,
    input  logic        uop_div,
    input  logic        uop_rem,
    input  logic        uop_mul,
    input  logic        uop_madd,
    input  logic        uop_msub_1,
    input  logic        uop_msub_2,
    input  logic        uop_macc_1,
    input  logic        uop_macc_2,
    input  logic        mod_lh_sign,
    input  logic        mod_rh_sign,
    input  logic        mod_carryless,
    input  logic        pw_32,
    input  logic        pw_16,
    input  logic        pw_8,
    input  logic        pw_4,
    input  logic        pw_2,
    output logic [63:0] result,
    output logic        ready
);
    typedef enum logic [1:0] {ST_IDLE, ST_BUSY, ST_DONE} state_t;

    state_t      state_q, state_d;
    logic [5:0]  count_q, count_d;
    logic [63:0] acc_q, acc_d;
    logic [63:0] result_q, result_d;

    logic is_div_rem, is_multi;
    assign is_div_rem = uop_div | uop_rem;
    assign is_multi   = is_div_rem | uop_mul;

    // Divider: acc holds {partial remainder, dividend/quotient shift register}
    logic        lhs_neg, rhs_neg;
    logic [31:0] lhs_mag, rhs_mag, quo, remd, quo_fix, rem_fix;
    logic [32:0] rem_shift, rem_diff;
    logic [63:0] div_step, div_final;

    always_comb begin
        lhs_neg   = mod_lh_sign & rs1[31];
        rhs_neg   = mod_lh_sign & rs2[31];
        lhs_mag   = lhs_neg ? (32'd0 - rs1) : rs1;
        rhs_mag   = rhs_neg ? (32'd0 - rs2) : rs2;
        rem_shift = {acc_q[63:32], acc_q[31]};
        rem_diff  = rem_shift - {1'b0, rhs_mag};
        div_step  = rem_diff[32] ? {rem_shift[31:0], acc_q[30:0], 1'b0}
                                 : {rem_diff[31:0],  acc_q[30:0], 1'b1};
        quo       = div_step[31:0];
        remd      = div_step[63:32];
        quo_fix   = (lhs_neg ^ rhs_neg) ? (32'd0 - quo) : quo;
        rem_fix   = lhs_neg ? (32'd0 - remd) : remd;
        if (rs2 == 32'd0) begin
            div_final = uop_rem ? {32'h0, rs1} : {32'h0, 32'hFFFF_FFFF};
        end else begin
            div_final = uop_rem ? {32'h0, rem_fix} : {32'h0, quo_fix};
        end
    end

    // Multiplier: acc holds each lane's 2w-bit product at offset 2w*lane
    logic [2:0]  lw_log;
    logic [5:0]  lw;
    logic [4:0]  jmask, bit_j, lane;
    logic [5:0]  lo_sh;
    logic [6:0]  wide_sh;
    logic [63:0] mask_w, mask_2w, a_lane, term, cur, nxt, mul_step, mul_final;
    logic        lh_sgn, rh_sgn;

    function automatic logic [5:0] lane_bit(input logic [4:0] k, input logic [2:0] lg,
                                            input logic hi);
        logic [4:0] jm;
        jm = (5'd1 << lg) - 5'd1;
        return ({1'b0, k & ~jm} << 1) + {1'b0, k & jm} + (hi ? (6'd1 << lg) : 6'd0);
    endfunction

    always_comb begin
        if (pw_32)      lw_log = 3'd5;
        else if (pw_16) lw_log = 3'd4;
        else if (pw_8)  lw_log = 3'd3;
        else if (pw_4)  lw_log = 3'd2;
        else if (pw_2)  lw_log = 3'd1;
        else            lw_log = 3'd5;
        lw      = 6'd1 << lw_log;
        jmask   = (5'd1 << lw_log) - 5'd1;
        lh_sgn  = mod_lh_sign & ~mod_carryless;
        rh_sgn  = mod_rh_sign & ~mod_carryless;
        bit_j   = count_q[4:0] & jmask;
        lane    = count_q[4:0] >> lw_log;
        lo_sh   = {1'b0, lane} << lw_log;
        wide_sh = {lo_sh, 1'b0};
        mask_w  = (64'd1 << lw) - 64'd1;
        // a 64-bit shift of 64 yields zero, so the 32-bit lane mask becomes all ones
        mask_2w = (64'd1 << {lw, 1'b0}) - 64'd1;
        a_lane  = ({32'h0, rs1} >> lo_sh) & mask_w;
        if (lh_sgn && a_lane[lw - 6'd1]) a_lane = a_lane | ~mask_w;
        term = a_lane << bit_j;
        if (rh_sgn && (bit_j == jmask)) term = 64'd0 - term;
        if (!rs2[count_q[4:0]]) term = 64'd0;
        term     = term & mask_2w;
        cur      = (acc_q >> wide_sh) & mask_2w;
        nxt      = (mod_carryless ? (cur ^ term) : (cur + term)) & mask_2w;
        mul_step = (acc_q & ~(mask_2w << wide_sh)) | (nxt << wide_sh);
        mul_final = 64'd0;
        for (int k = 0; k < 32; k++) begin
            mul_final[k]      = mul_step[lane_bit(5'(k), lw_log, 1'b0)];
            mul_final[k + 32] = mul_step[lane_bit(5'(k), lw_log, 1'b1)];
        end
    end

    logic [63:0] sc_res;
    always_comb begin
        sc_res = 64'd0;
        if (uop_madd)        sc_res = {31'h0, {1'b0, rs1} + {1'b0, rs2} + {32'h0, rs3[0]}};
        else if (uop_msub_1) sc_res = {32'h0, rs1} - {32'h0, rs2} - {63'h0, rs3[0]};
        else if (uop_msub_2) sc_res = {32'h0, rs1} - {32'h0, rs2} - {32'h0, rs3};
        else if (uop_macc_1) sc_res = {rs2, rs1} + {32'h0, rs3};
        else if (uop_macc_2) sc_res = {rs2, rs1} + {rs3, 32'h0};
    end

    always_comb begin
        state_d  = state_q;
        count_d  = count_q;
        acc_d    = acc_q;
        result_d = result_q;
        case (state_q)
            ST_IDLE: begin
                if (valid && !flush) begin
                    if (is_multi) begin
                        state_d = ST_BUSY;
                        count_d = 6'd0;
                        acc_d   = is_div_rem ? {32'h0, lhs_mag} : 64'd0;
                    end else begin
                        state_d  = ST_DONE;
                        result_d = sc_res;
                    end
                end
            end
            ST_BUSY: begin
                if (flush || !valid) begin
                    state_d = ST_IDLE;
                    count_d = 6'd0;
                end else begin
                    acc_d   = is_div_rem ? div_step : mul_step;
                    count_d = count_q + 6'd1;
                    if (count_q == 6'd31) begin
                        state_d  = ST_DONE;
                        result_d = is_div_rem ? div_final : mul_final;
                    end
                end
            end
            ST_DONE: begin
                if (flush) begin
                    state_d  = ST_IDLE;
                    count_d  = 6'd0;
                    result_d = 64'd0;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q  <= ST_IDLE;
            count_q  <= 6'd0;
            acc_q    <= 64'd0;
            result_q <= 64'd0;
        end else begin
            state_q  <= state_d;
            count_q  <= count_d;
            acc_q    <= acc_d;
            result_q <= result_d;
        end
    end

    assign result = result_q;
    assign ready  = (state_q == ST_DONE);
endmodule

// File: tb/tb_xc_malu_core.sv
// tb/tb_xc_malu_core.sv - directed and randomized self-checking bench for xc_malu_core.
module tb_xc_malu_core;
    localparam logic [7:0] U_DIV = 8'h01, U_REM = 8'h02, U_MUL = 8'h04, U_MADD = 8'h08;
    localparam logic [7:0] U_MSUB1 = 8'h10, U_MSUB2 = 8'h20, U_MACC1 = 8'h40, U_MACC2 = 8'h80;
    localparam logic [4:0] P32 = 5'h10, P16 = 5'h08, P8 = 5'h04, P4 = 5'h02, P2 = 5'h01;

    logic        clock = 1'b0;
    logic        reset, flush, valid;
    logic [31:0] rs1, rs2, rs3;
    logic [7:0]  uop_v;
    logic [4:0]  pw_v;
    logic        lh_s, rh_s, cl;
    logic [63:0] result;
    logic        ready;

    int n_tests = 0;
    int n_fail  = 0;
    int last_lat;

    always #5 clock = ~clock;

    xc_malu_core dut (
        .clock(clock), .reset(reset), .rs1(rs1), .rs2(rs2), .rs3(rs3),
        .flush(flush), .valid(valid),
        .uop_div(uop_v[0]), .uop_rem(uop_v[1]), .uop_mul(uop_v[2]), .uop_madd(uop_v[3]),
        .uop_msub_1(uop_v[4]), .uop_msub_2(uop_v[5]), .uop_macc_1(uop_v[6]), .uop_macc_2(uop_v[7]),
        .mod_lh_sign(lh_s), .mod_rh_sign(rh_s), .mod_carryless(cl),
        .pw_32(pw_v[4]), .pw_16(pw_v[3]), .pw_8(pw_v[2]), .pw_4(pw_v[1]), .pw_2(pw_v[0]),
        .result(result), .ready(ready)
    );

    task automatic check64(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic start_wait(input string tag, input logic [31:0] a, input logic [31:0] b,
                              input logic [31:0] c, input logic [7:0] u, input logic ls,
                              input logic rsg, input logic cless, input logic [4:0] pw);
        rs1 = a; rs2 = b; rs3 = c; uop_v = u; lh_s = ls; rh_s = rsg; cl = cless; pw_v = pw;
        valid = 1'b1;
        last_lat = 0;
        do begin
            @(negedge clock);
            last_lat++;
        end while (!ready && last_lat < 40);
        check64({tag, "_ready"}, {63'h0, ready}, 64'd1);
    endtask

    task automatic flush_op(input string tag);
        flush = 1'b1;
        @(negedge clock);
        flush = 1'b0; valid = 1'b0; uop_v = 8'h0;
        check64({tag, "_flushed"}, {63'h0, ready}, 64'd0);
    endtask

    task automatic run_op(input string tag, input logic [31:0] a, input logic [31:0] b,
                          input logic [31:0] c, input logic [7:0] u, input logic ls,
                          input logic rsg, input logic cless, input logic [4:0] pw,
                          input logic [63:0] exp);
        start_wait(tag, a, b, c, u, ls, rsg, cless, pw);
        check64(tag, result, exp);
        flush_op(tag);
    endtask

    function automatic logic [63:0] ref_divrem(input logic [31:0] a, input logic [31:0] b,
                                               input logic sgn, input logic is_rem);
        logic [31:0] r;
        if (b == 32'd0) return is_rem ? {32'h0, a} : {32'h0, 32'hFFFF_FFFF};
        if (sgn) begin
            if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return is_rem ? 64'd0 : 64'h8000_0000;
            r = is_rem ? 32'($signed(a) % $signed(b)) : 32'($signed(a) / $signed(b));
        end else begin
            r = is_rem ? a % b : a / b;
        end
        return {32'h0, r};
    endfunction

    initial begin
        logic [31:0] ra, rb;
        logic        rsgn, rrem;
        reset = 1'b1; flush = 1'b0; valid = 1'b0;
        rs1 = 0; rs2 = 0; rs3 = 0; uop_v = 0; pw_v = P32; lh_s = 0; rh_s = 0; cl = 0;
        repeat (2) @(negedge clock);
        check64("reset_ready", {63'h0, ready}, 64'd0);
        check64("reset_result", result, 64'd0);
        reset = 1'b0;
        @(negedge clock);

        // 100/7 with ready held until flush
        start_wait("div_100_7", 32'd100, 32'd7, 0, U_DIV, 0, 0, 0, P32);
        check64("div_100_7", result, 64'h0000_0000_0000_000E);
        check64("div_lat", {63'h0, (last_lat >= 2 && last_lat <= 34)}, 64'd1);
        repeat (3) @(negedge clock);
        check64("div_hold_ready", {63'h0, ready}, 64'd1);
        check64("div_hold_result", result, 64'h0000_0000_0000_000E);
        flush_op("div_100_7");

        run_op("div_by0", 32'h1234_5678, 0, 0, U_DIV, 0, 0, 0, P32, 64'h0000_0000_FFFF_FFFF);
        run_op("rem_by0", 32'h1234_5678, 0, 0, U_REM, 0, 0, 0, P32, 64'h0000_0000_1234_5678);
        run_op("srem_m7_2", 32'hFFFF_FFF9, 2, 0, U_REM, 1, 1, 0, P32, 64'h0000_0000_FFFF_FFFF);
        run_op("sdiv_m7_2", 32'hFFFF_FFF9, 2, 0, U_DIV, 1, 1, 0, P32, 64'h0000_0000_FFFF_FFFD);
        run_op("sdiv_ovf", 32'h8000_0000, 32'hFFFF_FFFF, 0, U_DIV, 1, 1, 0, P32, 64'h0000_0000_8000_0000);
        run_op("srem_ovf", 32'h8000_0000, 32'hFFFF_FFFF, 0, U_REM, 1, 1, 0, P32, 64'h0);

        run_op("mul_uu_max", 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0, U_MUL, 0, 0, 0, P32, 64'hFFFF_FFFE_0000_0001);
        run_op("mul_ss", 32'hFFFF_FFFE, 32'd3, 0, U_MUL, 1, 1, 0, P32, 64'hFFFF_FFFF_FFFF_FFFA);
        run_op("mul_su", 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0, U_MUL, 1, 0, 0, P32, 64'hFFFF_FFFF_0000_0001);
        run_op("clmul_3_3", 32'd3, 32'd3, 0, U_MUL, 0, 0, 1, P32, 64'h5);
        run_op("mul_p8_u", 32'hFF10_0302, 32'hFF10_0507, 0, U_MUL, 0, 0, 0, P8, 64'hFE01_0000_0100_0F0E);
        run_op("mul_p8_s", 32'hFF10_0302, 32'hFF10_0507, 0, U_MUL, 1, 1, 0, P8, 64'h0001_0000_0100_0F0E);
        run_op("clmul_p16", 32'h0003_0005, 32'h0003_0003, 0, U_MUL, 0, 0, 1, P16, 64'h0000_0000_0005_000F);
        run_op("mul_p2_u", 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0, U_MUL, 0, 0, 0, P2, 64'hAAAA_AAAA_5555_5555);
        run_op("mul_p2_s", 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0, U_MUL, 1, 1, 0, P2, 64'h0000_0000_5555_5555);

        start_wait("madd", 32'hFFFF_FFFF, 32'd1, 32'd1, U_MADD, 0, 0, 0, P32);
        check64("madd", result, 64'h0000_0001_0000_0001);
        check64("madd_lat", 64'(last_lat), 64'd1);
        flush_op("madd");
        run_op("msub1", 32'd5, 32'd7, 32'd1, U_MSUB1, 0, 0, 0, P32, 64'hFFFF_FFFF_FFFF_FFFD);
        run_op("msub2", 32'd1, 32'd2, 32'h10, U_MSUB2, 0, 0, 0, P32, 64'hFFFF_FFFF_FFFF_FFEF);
        run_op("macc1", 32'hFFFF_FFFF, 32'd1, 32'd1, U_MACC1, 0, 0, 0, P32, 64'h0000_0002_0000_0000);
        run_op("macc2", 32'h1234_5678, 32'hFFFF_FFFF, 32'd2, U_MACC2, 0, 0, 0, P32, 64'h0000_0001_1234_5678);
        start_wait("no_uop", 32'd9, 32'd9, 32'd9, 8'h00, 0, 0, 0, P32);
        check64("no_uop", result, 64'h0);
        check64("no_uop_lat", 64'(last_lat), 64'd1);
        flush_op("no_uop");

        // abandon a divide mid-flight, then a fresh op must work
        rs1 = 32'd100; rs2 = 32'd7; uop_v = U_DIV; lh_s = 0; rh_s = 0; valid = 1'b1;
        repeat (5) @(negedge clock);
        check64("abandon_busy", {63'h0, ready}, 64'd0);
        valid = 1'b0;
        repeat (40) @(negedge clock);
        check64("abandon_idle", {63'h0, ready}, 64'd0);
        run_op("after_abandon", 32'd5, 32'd6, 32'd0, U_MADD, 0, 0, 0, P32, 64'd11);

        // valid held through flush: new op starts only after the flush cycle
        start_wait("flush_valid_a", 32'd1, 32'd2, 32'd0, U_MADD, 0, 0, 0, P32);
        check64("flush_valid_a", result, 64'd3);
        rs1 = 32'd20; rs2 = 32'd22; flush = 1'b1;
        @(negedge clock);
        flush = 1'b0;
        check64("flush_valid_gap", {63'h0, ready}, 64'd0);
        @(negedge clock);
        check64("flush_valid_rdy", {63'h0, ready}, 64'd1);
        check64("flush_valid_b", result, 64'd42);
        flush_op("flush_valid_b");

        // reset in the middle of a divide
        rs1 = 32'd1000; rs2 = 32'd3; uop_v = U_DIV; valid = 1'b1;
        repeat (10) @(negedge clock);
        reset = 1'b1;
        @(negedge clock);
        check64("midrst_ready", {63'h0, ready}, 64'd0);
        check64("midrst_result", result, 64'd0);
        reset = 1'b0; valid = 1'b0;
        @(negedge clock);
        check64("midrst_idle", {63'h0, ready}, 64'd0);
        run_op("after_rst", 32'd1000, 32'd3, 0, U_DIV, 0, 0, 0, P32, 64'd333);

        for (int i = 0; i < 80; i++) begin
            case ($urandom_range(0, 4))
                0:       rb = 32'd0;
                1:       rb = $urandom_range(1, 15);
                2:       rb = 32'hFFFF_FFFF;
                default: rb = $urandom;
            endcase
            ra   = ($urandom_range(0, 7) == 0) ? 32'h8000_0000 : $urandom;
            rsgn = 1'($urandom_range(0, 1));
            rrem = 1'($urandom_range(0, 1));
            run_op($sformatf("rnd%0d", i), ra, rb, 0, rrem ? U_REM : U_DIV, rsgn, rsgn, 0, P32,
                   ref_divrem(ra, rb, rsgn, rrem));
            repeat ($urandom_range(0, 3)) @(negedge clock);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
